// File: rtl/lt24_pixel_feeder.sv
// SPI-register-to-LCD pixel feeder: a write to ADDR_B packs the RGB888 registers to
// RGB565, tags it with (x,y) raster coordinates and queues it in a FWFT FIFO.
module lt24_pixel_feeder #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WIDTH  = 240,
    parameter int unsigned HEIGHT = 320,
    parameter logic [6:0]  ADDR_B = 7'h14
) (
    input  logic        theClock,
    input  logic        theReset,
    input  logic        spi_irq,
    input  logic        spi_write,
    input  logic [6:0]  spi_addr,
    input  logic [7:0]  pix_r,
    input  logic [7:0]  pix_g,
    input  logic [7:0]  pix_b,
    input  logic        cfg_clear,
    input  logic        px_ready,
    output logic        px_valid,
    output logic [15:0] px_data,
    output logic [7:0]  px_x,
    output logic [8:0]  px_y,
    output logic [6:0]  fifo_level,
    output logic        overflow,
    output logic        frame_done
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [6:0]  LVL_FULL = 7'(DEPTH);
    localparam logic [7:0]  X_LAST   = 8'(WIDTH - 1);
    localparam logic [8:0]  Y_LAST   = 9'(HEIGHT - 1);

    typedef enum logic {S_Idle, S_Push} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [6:0]      level_q, level_d;
    logic [7:0]      x_q, x_d;
    logic [8:0]      y_q, y_d;
    logic            ovf_q, ovf_d;
    logic            fd_q, fd_d;
    logic [32:0]     mem_q [DEPTH];

    logic            trigger, in_push, pop, full, push_ok, push_drop;
    logic [15:0]     pix_word;
    logic [32:0]     head;
    logic            unused_pix_lsbs;

    assign trigger   = spi_irq & spi_write & (spi_addr == ADDR_B);
    assign in_push   = (state_q == S_Push);
    assign pop       = (level_q != 7'd0) & px_ready;
    assign full      = (level_q == LVL_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok   = in_push & ~cfg_clear & (~full | pop);
    assign push_drop = in_push & full & ~pop;
    assign pix_word  = {pix_r[7:3], pix_g[7:2], pix_b[7:3]};
    assign unused_pix_lsbs = ^{pix_r[2:0], pix_g[1:0], pix_b[2:0]};

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        x_d      = x_q;
        y_d      = y_q;
        ovf_d    = ovf_q;
        fd_d     = 1'b0;
        if (cfg_clear) begin
            state_d  = S_Idle;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            x_d      = '0;
            y_d      = '0;
            ovf_d    = 1'b0;
        end else begin
            state_d = (!in_push && trigger) ? S_Push : S_Idle;
            ovf_d   = ovf_q | push_drop | (in_push & trigger);
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                fd_d     = (x_q == X_LAST) && (y_q == Y_LAST);
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = (y_q == Y_LAST) ? 9'd0 : y_q + 9'd1;
                end else begin
                    x_d = x_q + 8'd1;
                end
            end
            case ({push_ok, pop})
                2'b10:   level_d = level_q + 7'd1;
                2'b01:   level_d = level_q - 7'd1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge theClock or negedge theReset) begin
        if (!theReset) begin
            state_q  <= S_Idle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            ovf_q    <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ovf_q    <= ovf_d;
            fd_q     <= fd_d;
        end
    end

    // Storage needs no reset: an empty FIFO masks the head to zero.
    always_ff @(posedge theClock) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= {pix_word, x_q, y_q};
    end

    assign head       = mem_q[rd_ptr_q];
    assign px_valid   = (level_q != 7'd0);
    assign px_data    = px_valid ? head[32:17] : 16'd0;
    assign px_x       = px_valid ? head[16:9]  : 8'd0;
    assign px_y       = px_valid ? head[8:0]   : 9'd0;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_lt24_pixel_feeder.sv
// Bench for lt24_pixel_feeder: directed scenarios plus random traffic against a
// queue-based model; a second instance with a 4x2 frame exercises raster wrap.
module tb_lt24_pixel_feeder;

    localparam int D = 16;
    localparam int W = 240;
    localparam int H = 320;

    logic        theClock, theReset;
    logic        spi_irq, spi_write, cfg_clear, px_ready;
    logic [6:0]  spi_addr;
    logic [7:0]  pix_r, pix_g, pix_b;

    logic        px_valid, overflow, frame_done;
    logic [15:0] px_data;
    logic [7:0]  px_x;
    logic [8:0]  px_y;
    logic [6:0]  fifo_level;

    logic        px_valid_f, overflow_f, frame_done_f;
    logic [15:0] px_data_f;
    logic [7:0]  px_x_f;
    logic [8:0]  px_y_f;
    logic [6:0]  fifo_level_f;

    int n_checks = 0;
    int n_fail   = 0;

    lt24_pixel_feeder dut (
        .theClock(theClock), .theReset(theReset), .spi_irq(spi_irq), .spi_write(spi_write),
        .spi_addr(spi_addr), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .cfg_clear(cfg_clear), .px_ready(px_ready), .px_valid(px_valid), .px_data(px_data),
        .px_x(px_x), .px_y(px_y), .fifo_level(fifo_level), .overflow(overflow),
        .frame_done(frame_done)
    );

    lt24_pixel_feeder #(.DEPTH(16), .WIDTH(4), .HEIGHT(2), .ADDR_B(7'h14)) dut_f (
        .theClock(theClock), .theReset(theReset), .spi_irq(spi_irq), .spi_write(spi_write),
        .spi_addr(spi_addr), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .cfg_clear(cfg_clear), .px_ready(px_ready), .px_valid(px_valid_f), .px_data(px_data_f),
        .px_x(px_x_f), .px_y(px_y_f), .fifo_level(fifo_level_f), .overflow(overflow_f),
        .frame_done(frame_done_f)
    );

    initial theClock = 1'b0;
    always #5 theClock = ~theClock;

    logic [42:0] obs, obs_f;
    assign obs   = {px_valid, px_data, px_x, px_y, fifo_level, overflow, frame_done};
    assign obs_f = {px_valid_f, px_data_f, px_x_f, px_y_f, fifo_level_f, overflow_f, frame_done_f};

    // Reference model: queue of {rgb565, x, y}, raster counters, flags.
    logic [32:0] mq[$];
    int mx, my;
    bit movf, mfd, mpend;

    function automatic void model_reset();
        mq.delete();
        mx = 0; my = 0; movf = 0; mfd = 0; mpend = 0;
    endfunction

    function automatic void model_step();
        bit trig, pop;
        int word;
        trig = spi_irq && spi_write && (spi_addr == 7'h14);
        pop  = (mq.size() != 0) && px_ready;
        mfd  = 0;
        if (!theReset) begin
            model_reset();
            return;
        end
        if (cfg_clear) begin
            model_reset();
            return;
        end
        if (pop) void'(mq.pop_front());
        if (mpend) begin
            if (mq.size() < D) begin
                word = ((int'(pix_r) / 8) * 2048) + ((int'(pix_g) / 4) * 32) + (int'(pix_b) / 8);
                mq.push_back({16'(word), 8'(mx), 9'(my)});
                mfd = (mx == W - 1) && (my == H - 1);
                mx++;
                if (mx == W) begin
                    mx = 0;
                    my++;
                    if (my == H) my = 0;
                end
            end else begin
                movf = 1;
            end
            if (trig) movf = 1;
            mpend = 0;
        end else begin
            mpend = trig;
        end
    endfunction

    function automatic logic [42:0] exp_vec();
        logic [32:0] hd;
        hd = (mq.size() != 0) ? mq[0] : 33'd0;
        return {mq.size() != 0, hd, 7'(mq.size()), movf, mfd};
    endfunction

    task automatic rpix();
        pix_r = 8'($urandom); pix_g = 8'($urandom); pix_b = 8'($urandom);
    endtask

    // Caller sits at a negedge; inputs are applied, the model advances, one clock passes.
    task automatic cyc(input bit irq, input bit wr, input logic [6:0] addr,
                       input bit rdy, input bit clr);
        spi_irq = irq; spi_write = wr; spi_addr = addr; px_ready = rdy; cfg_clear = clr;
        model_step();
        @(posedge theClock);
        @(negedge theClock);
    endtask

    task automatic test_reset();
        theReset = 1'b0;
        px_ready = 1'b1;
        pix_r = 8'h00; pix_g = 8'h00; pix_b = 8'h00;
        @(negedge theClock);
        cyc(1, 1, 7'h14, 1, 0);
        cyc(1, 1, 7'h14, 1, 0);
        n_checks++;
        if (obs !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        n_checks++;
        if (obs_f !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_f: got %h want 0", obs_f);
        end
    endtask

    task automatic test_single_pixel();
        theReset = 1'b1;
        pix_r = 8'hFF; pix_g = 8'h00; pix_b = 8'hFF;
        cyc(1, 1, 7'h14, 1, 0);
        n_checks++;
        if (px_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_t1_valid: got %b want 0", px_valid);
        end
        cyc(0, 0, 7'h00, 1, 0);
        n_checks++;
        if ({px_valid, px_data, px_x, px_y} !== {1'b1, 16'hF81F, 8'd0, 9'd0}) begin
            n_fail++;
            $display("FAIL single_t2_head: got v=%b d=%h x=%0d y=%0d want v=1 d=f81f x=0 y=0",
                     px_valid, px_data, px_x, px_y);
        end
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL single_t2_model: got %h want %h", obs, exp_vec());
        end
        cyc(0, 0, 7'h00, 1, 0);
        n_checks++;
        if ({px_valid, fifo_level} !== {1'b0, 7'd0}) begin
            n_fail++;
            $display("FAIL single_popped: got v=%b lvl=%0d want v=0 lvl=0", px_valid, fifo_level);
        end
    endtask

    task automatic test_addr_filter();
        cyc(1, 1, 7'h12, 0, 0);
        cyc(0, 0, 7'h00, 0, 0);
        cyc(1, 1, 7'h13, 0, 0);
        cyc(0, 0, 7'h00, 0, 0);
        cyc(1, 0, 7'h14, 0, 0);
        cyc(0, 0, 7'h00, 0, 0);
        cyc(0, 0, 7'h00, 0, 0);
        n_checks++;
        if ({px_valid, fifo_level, overflow} !== {1'b0, 7'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL addr_filter: got v=%b lvl=%0d ovf=%b want 0/0/0",
                     px_valid, fifo_level, overflow);
        end
    endtask

    task automatic test_overflow();
        cyc(0, 0, 7'h00, 0, 1);
        for (int i = 0; i < D + 1; i++) begin
            rpix();
            cyc(1, 1, 7'h14, 0, 0);
            cyc(0, 0, 7'h00, 0, 0);
        end
        n_checks++;
        if ({fifo_level, overflow} !== {7'(D), 1'b1}) begin
            n_fail++;
            $display("FAIL overflow_full: got lvl=%0d ovf=%b want %0d/1", fifo_level, overflow, D);
        end
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL overflow_model: got %h want %h", obs, exp_vec());
        end
        for (int i = 0; i < D; i++) begin
            n_checks++;
            if ({px_valid, px_x, px_y} !== {1'b1, 8'(i), 9'd0}) begin
                n_fail++;
                $display("FAIL overflow_drain[%0d]: got v=%b x=%0d y=%0d want v=1 x=%0d y=0",
                         i, px_valid, px_x, px_y, i);
            end
            cyc(0, 0, 7'h00, 1, 0);
        end
        n_checks++;
        if ({fifo_level, overflow} !== {7'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL overflow_sticky: got lvl=%0d ovf=%b want 0/1", fifo_level, overflow);
        end
    endtask

    task automatic test_full_pop();
        cyc(0, 0, 7'h00, 0, 1);
        for (int i = 0; i < D; i++) begin
            rpix();
            cyc(1, 1, 7'h14, 0, 0);
            cyc(0, 0, 7'h00, 0, 0);
        end
        cyc(1, 1, 7'h14, 0, 0);
        cyc(0, 0, 7'h00, 1, 0);
        n_checks++;
        if ({fifo_level, overflow, px_x} !== {7'(D), 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL full_pop: got lvl=%0d ovf=%b x=%0d want %0d/0/1",
                     fifo_level, overflow, px_x, D);
        end
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL full_pop_model: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_frame_wrap();
        int pulses, pulse_at;
        pulses = 0; pulse_at = -1;
        cyc(0, 0, 7'h00, 0, 1);
        for (int i = 0; i < 9; i++) begin
            rpix();
            cyc(1, 1, 7'h14, 0, 0);
            if (frame_done_f) pulses++;
            cyc(0, 0, 7'h00, 0, 0);
            if (frame_done_f) begin pulses++; pulse_at = i; end
        end
        cyc(0, 0, 7'h00, 0, 0);
        if (frame_done_f) pulses++;
        n_checks++;
        if (pulses != 1 || pulse_at != 7) begin
            n_fail++;
            $display("FAIL frame_done_pulse: got count=%0d after_pixel=%0d want 1 after 7",
                     pulses, pulse_at);
        end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if ({px_valid_f, px_x_f, px_y_f} !== {1'b1, 8'(i % 4), 9'((i / 4) % 2)}) begin
                n_fail++;
                $display("FAIL frame_coord[%0d]: got v=%b (%0d,%0d) want (%0d,%0d)",
                         i, px_valid_f, px_x_f, px_y_f, i % 4, (i / 4) % 2);
            end
            cyc(0, 0, 7'h00, 1, 0);
        end
    endtask

    task automatic test_clear();
        cyc(0, 0, 7'h00, 0, 1);
        for (int i = 0; i < 4; i++) begin
            rpix();
            cyc(1, 1, 7'h14, 0, 0);
            cyc(0, 0, 7'h00, 0, 0);
        end
        cyc(1, 1, 7'h14, 0, 0);
        cyc(1, 1, 7'h14, 0, 0);
        cyc(0, 0, 7'h00, 0, 0);
        n_checks++;
        if ({fifo_level, overflow} !== {7'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL clear_setup: got lvl=%0d ovf=%b want 5/1", fifo_level, overflow);
        end
        cyc(1, 1, 7'h14, 0, 0);
        cyc(0, 0, 7'h00, 0, 1);
        n_checks++;
        if ({fifo_level, px_valid, overflow} !== {7'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_flush: got lvl=%0d v=%b ovf=%b want 0/0/0",
                     fifo_level, px_valid, overflow);
        end
        cyc(0, 0, 7'h00, 0, 0);
        n_checks++;
        if (fifo_level !== 7'd0) begin
            n_fail++;
            $display("FAIL clear_no_push: got lvl=%0d want 0", fifo_level);
        end
        rpix();
        cyc(1, 1, 7'h14, 0, 0);
        cyc(0, 0, 7'h00, 0, 0);
        n_checks++;
        if ({px_valid, px_x, px_y, fifo_level} !== {1'b1, 8'd0, 9'd0, 7'd1}) begin
            n_fail++;
            $display("FAIL clear_next: got v=%b (%0d,%0d) lvl=%0d want (0,0) lvl=1",
                     px_valid, px_x, px_y, fifo_level);
        end
    endtask

    task automatic test_async_reset();
        cyc(0, 0, 7'h00, 0, 1);
        for (int i = 0; i < 5; i++) begin
            rpix();
            cyc(1, 1, 7'h14, 0, 0);
            cyc(0, 0, 7'h00, 0, 0);
        end
        cyc(1, 1, 7'h14, 0, 0);
        #1 theReset = 1'b0;
        #1;
        n_checks++;
        if (obs !== 43'd0) begin
            n_fail++;
            $display("FAIL async_reset_now: got %h want 0", obs);
        end
        model_reset();
        @(negedge theClock);
        theReset = 1'b1;
        rpix();
        cyc(1, 1, 7'h14, 0, 0);
        cyc(0, 0, 7'h00, 0, 0);
        n_checks++;
        if ({px_valid, px_x, px_y, fifo_level} !== {1'b1, 8'd0, 9'd0, 7'd1}) begin
            n_fail++;
            $display("FAIL async_reset_next: got v=%b (%0d,%0d) lvl=%0d want (0,0) lvl=1",
                     px_valid, px_x, px_y, fifo_level);
        end
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_reset_model: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [6:0] addrs [4];
        addrs[0] = 7'h12; addrs[1] = 7'h13; addrs[2] = 7'h14; addrs[3] = 7'h14;
        cyc(0, 0, 7'h00, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            rpix();
            cyc($urandom_range(1, 0) == 1, $urandom_range(3, 0) != 0, addrs[$urandom_range(3, 0)],
                $urandom_range(2, 0) == 0, $urandom_range(99, 0) == 0);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        theReset = 1'b0; spi_irq = 1'b0; spi_write = 1'b0; spi_addr = 7'h00;
        cfg_clear = 1'b0; px_ready = 1'b0;
        model_reset();
        test_reset();
        test_single_pixel();
        test_addr_filter();
        test_overflow();
        test_full_pop();
        test_frame_wrap();
        test_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
